uart_frame_parser: RTL and testbench
====================================

Name: uart_frame_parser

Overview:
Receive-side decoder for the 12-byte road-status UART frame produced by the VGA/vision board. It consumes the byte strobe from the UART receiver, hunts for the 0xAB header, collects and format-checks the 11 payload bytes, and publishes a coherent field set. Sits between the uart_controller RX path and the road-control/display logic, which read its registered outputs.

Parameters:
HEADER, 8'hAB, frame sync byte
FRAME_LEN, 12, total bytes per frame including header
TIMEOUT_CYC, 50000, max clk cycles allowed between payload bytes before the frame is aborted (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  one-cycle strobe: in_data holds a received byte
in_data  in  8  received byte
x_min  out  10  bbox x min, last good frame
x_max  out  10  bbox x max, last good frame
y_min  out  10  bbox y min, last good frame
y_max  out  10  bbox y max, last good frame
red_left_time  out  5  byte 1 bits [4:0], as received (no offset correction)
green_left_time  out  5  byte 2 bits [4:0], as received
traffic_light  out  1  flags bit7 (1=green, 0=red)
human_violation  out  1  flags bit6
car_violation  out  1  flags bit5
traffic_amount  out  1  flags bit4 (0=low, 1=high)
frame_valid  out  1  one-cycle pulse: outputs just updated with a new frame
frame_err  out  1  one-cycle pulse: frame aborted (format error or timeout)
frame_cnt  out  8  good-frame count, wraps 255->0
err_cnt  out  8  aborted-frame count, saturates at 255

Behaviour:
- Frame byte order: 0 header; 1 red time; 2 green time; 3/4 x_min hi/lo; 5/6 x_max hi/lo; 7/8 y_min hi/lo; 9/10 y_max hi/lo; 11 flags. Hi bytes carry bits [9:8] in [1:0].
- Reset: state HUNT, byte index 0, all field outputs 0, frame_valid 0, frame_err 0, frame_cnt 0, err_cnt 0, timeout counter 0, shadow registers 0.
- States: HUNT, COLLECT.
- HUNT: in_valid && in_data==HEADER -> COLLECT, idx=1, timeout counter cleared; every other byte is ignored silently (no frame_err).
- COLLECT: each in_valid byte is format-checked and written into the shadow register for idx; idx increments. Format rules: bytes 1,2 need [7:5]==0; hi bytes 3,5,7,9 need [7:2]==0; flags byte 11 needs [3:0]==0; lo bytes are unchecked.
- Format error: frame_err pulses the next cycle, err_cnt++ (saturating), shadow discarded, outputs unchanged. Resync: if the offending byte equals HEADER, go to COLLECT with idx=1; otherwise go to HUNT.
- Byte 11 passes check: the cycle after its in_valid, all field outputs load from the shadow registers (flags taken directly from the byte) simultaneously, frame_valid pulses, frame_cnt++; state HUNT.
- Outputs hold the last good frame until the next good frame completes. A partial frame never changes any output.
- Timeout: in COLLECT, the counter increments every cycle without in_valid and clears on in_valid. Reaching TIMEOUT_CYC -> frame_err pulse, err_cnt++, state HUNT. An in_valid in the same cycle the count reaches the limit takes priority: the byte is processed and no timeout occurs.
- frame_valid and frame_err are registered and never assert in the same cycle.
- Back-to-back in_valid on consecutive cycles is supported. The header of the next frame may arrive the cycle after byte 11.
- Async reset mid-frame: immediate return to reset values. No pulse is generated.

Decomposition:
- Package uart_frame_pkg:
  - HEADER and FRAME_LEN constants
  - byte-index localparams (IDX_RED .. IDX_FLAGS)
  - state enum (HUNT, COLLECT)
  - packed struct road_frame_t holding all decoded fields; shared with the sender side.
- No sub-module required. The timeout counter is inline.

Test Plan:
- Good frame: AB 09 13 01 2C 02 58 00 64 01 90 B0 -> one cycle later frame_valid=1; x_min=300, x_max=600, y_min=100, y_max=400, red=9, green=19, light=1, human=0, car=1, amount=1; frame_cnt=1.
- Leading garbage: 00 FF 12 then the good frame -> no frame_err; one frame_valid; fields as above.
- Format error: AB 09 13 FC ... -> frame_err on the byte after FC, err_cnt=1, outputs still 0. Then AB 05 ... 00 -> frame_valid, red=5.
- Resync: AB 09 AB followed by 11 valid bytes -> one frame_err at the second AB (bad green byte); the frame starting at the second AB is accepted.
- Timeout with TIMEOUT_CYC=100: AB 09 then 100 idle cycles -> frame_err exactly 100 cycles after the last byte, state HUNT. Same case with a byte at cycle 100 -> no error.
- Back-to-back: 3 good frames with zero gap -> 3 frame_valid pulses, frame_cnt=3. Reset asserted mid-frame 4 -> all outputs 0, no pulse.

Source files
------------

// File: rtl/uart_frame_pkg.sv
// Shared definitions for the road-status UART frame: sync byte, byte layout,
// parser states and the decoded field record used by both ends of the link.
package uart_frame_pkg;

   localparam logic [7:0]  HEADER    = 8'hAB;
   localparam int unsigned FRAME_LEN = 12;

   // Byte positions within a frame; hi bytes carry bits [9:8] in [1:0].
   localparam logic [3:0] IDX_HEADER   = 4'd0;
   localparam logic [3:0] IDX_RED      = 4'd1;
   localparam logic [3:0] IDX_GREEN    = 4'd2;
   localparam logic [3:0] IDX_XMIN_HI  = 4'd3;
   localparam logic [3:0] IDX_XMIN_LO  = 4'd4;
   localparam logic [3:0] IDX_XMAX_HI  = 4'd5;
   localparam logic [3:0] IDX_XMAX_LO  = 4'd6;
   localparam logic [3:0] IDX_YMIN_HI  = 4'd7;
   localparam logic [3:0] IDX_YMIN_LO  = 4'd8;
   localparam logic [3:0] IDX_YMAX_HI  = 4'd9;
   localparam logic [3:0] IDX_YMAX_LO  = 4'd10;
   localparam logic [3:0] IDX_FLAGS    = 4'(FRAME_LEN - 1);

   typedef enum logic {HUNT, COLLECT} state_t;

   typedef struct packed {
      logic [9:0] x_min;
      logic [9:0] x_max;
      logic [9:0] y_min;
      logic [9:0] y_max;
      logic [4:0] red_left_time;
      logic [4:0] green_left_time;
      logic       traffic_light;
      logic       human_violation;
      logic       car_violation;
      logic       traffic_amount;
   } road_frame_t;

   // Reserved bits that must be zero for the byte at position idx.
   function automatic logic byte_ok(input logic [3:0] idx, input logic [7:0] b);
      logic ok;
      case (idx)
         IDX_RED, IDX_GREEN:                            ok = (b[7:5] == 3'b000);
         IDX_XMIN_HI, IDX_XMAX_HI,
         IDX_YMIN_HI, IDX_YMAX_HI:                      ok = (b[7:2] == 6'b000000);
         IDX_FLAGS:                                     ok = (b[3:0] == 4'b0000);
         default:                                       ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/uart_frame_parser.sv
// Receive-side decoder for the 12-byte road-status frame. Hunts for the
// header, collects and checks the payload into a shadow record, and only
// publishes the field set once the whole frame has passed.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic [9:0] x_min,
   output logic [9:0] x_max,
   output logic [9:0] y_min,
   output logic [9:0] y_max,
   output logic [4:0] red_left_time,
   output logic [4:0] green_left_time,
   output logic       traffic_light,
   output logic       human_violation,
   output logic       car_violation,
   output logic       traffic_amount,
   output logic       frame_valid,
   output logic       frame_err,
   output logic [7:0] frame_cnt,
   output logic [7:0] err_cnt
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

   state_t      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic [TW-1:0] tmo_q, tmo_d;
   road_frame_t shadow_q, shadow_d;
   road_frame_t frame_q, frame_d;
   logic        valid_q, valid_d;
   logic        err_q, err_d;
   logic [7:0]  fcnt_q, fcnt_d;
   logic [7:0]  ecnt_q, ecnt_d;

   // Next-state: frame sequencing, shadow capture, publish and abort.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      tmo_d    = tmo_q;
      shadow_d = shadow_q;
      frame_d  = frame_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      fcnt_d   = fcnt_q;
      ecnt_d   = ecnt_q;

      case (state_q)
         HUNT: begin
            tmo_d = '0;
            idx_d = IDX_HEADER;
            if (in_valid && in_data == HEADER) begin
               state_d = COLLECT;
               idx_d   = IDX_RED;
            end
         end

         COLLECT: begin
            if (in_valid) begin
               // A byte always wins over a timeout landing in the same cycle.
               tmo_d = '0;
               if (!byte_ok(idx_q, in_data)) begin
                  err_d    = 1'b1;
                  shadow_d = '0;
                  if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
                  // The offending byte may itself be the next frame's header.
                  if (in_data == HEADER) begin
                     state_d = COLLECT;
                     idx_d   = IDX_RED;
                  end else begin
                     state_d = HUNT;
                     idx_d   = IDX_HEADER;
                  end
               end else if (idx_q == IDX_FLAGS) begin
                  frame_d                 = shadow_q;
                  frame_d.traffic_light   = in_data[7];
                  frame_d.human_violation = in_data[6];
                  frame_d.car_violation   = in_data[5];
                  frame_d.traffic_amount  = in_data[4];
                  valid_d  = 1'b1;
                  fcnt_d   = fcnt_q + 8'd1;
                  shadow_d = '0;
                  state_d  = HUNT;
                  idx_d    = IDX_HEADER;
               end else begin
                  case (idx_q)
                     IDX_RED:     shadow_d.red_left_time   = in_data[4:0];
                     IDX_GREEN:   shadow_d.green_left_time = in_data[4:0];
                     IDX_XMIN_HI: shadow_d.x_min[9:8]      = in_data[1:0];
                     IDX_XMIN_LO: shadow_d.x_min[7:0]      = in_data;
                     IDX_XMAX_HI: shadow_d.x_max[9:8]      = in_data[1:0];
                     IDX_XMAX_LO: shadow_d.x_max[7:0]      = in_data;
                     IDX_YMIN_HI: shadow_d.y_min[9:8]      = in_data[1:0];
                     IDX_YMIN_LO: shadow_d.y_min[7:0]      = in_data;
                     IDX_YMAX_HI: shadow_d.y_max[9:8]      = in_data[1:0];
                     IDX_YMAX_LO: shadow_d.y_max[7:0]      = in_data;
                     default: ;
                  endcase
                  idx_d = idx_q + 4'd1;
               end
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               err_d    = 1'b1;
               shadow_d = '0;
               tmo_d    = '0;
               if (ecnt_q != 8'hFF) ecnt_d = ecnt_q + 8'd1;
               state_d  = HUNT;
               idx_d    = IDX_HEADER;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         default: begin
            state_d = HUNT;
            idx_d   = IDX_HEADER;
         end
      endcase
   end

   // State, shadow, published fields and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= HUNT;
         idx_q    <= IDX_HEADER;
         tmo_q    <= '0;
         shadow_q <= '0;
         frame_q  <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         fcnt_q   <= 8'd0;
         ecnt_q   <= 8'd0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         tmo_q    <= tmo_d;
         shadow_q <= shadow_d;
         frame_q  <= frame_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         fcnt_q   <= fcnt_d;
         ecnt_q   <= ecnt_d;
      end
   end

   assign x_min           = frame_q.x_min;
   assign x_max           = frame_q.x_max;
   assign y_min           = frame_q.y_min;
   assign y_max           = frame_q.y_max;
   assign red_left_time   = frame_q.red_left_time;
   assign green_left_time = frame_q.green_left_time;
   assign traffic_light   = frame_q.traffic_light;
   assign human_violation = frame_q.human_violation;
   assign car_violation   = frame_q.car_violation;
   assign traffic_amount  = frame_q.traffic_amount;
   assign frame_valid     = valid_q;
   assign frame_err       = err_q;
   assign frame_cnt       = fcnt_q;
   assign err_cnt         = ecnt_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Randomized bench for uart_frame_parser: the driver feeds a byte-list
// reference model that queues expected pulses; a monitor checks each pulse.
module tb_uart_frame_parser;
   import uart_frame_pkg::*;

   localparam int TMO = 100;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic [9:0] x_min, x_max, y_min, y_max;
   logic [4:0] red_left_time, green_left_time;
   logic       traffic_light, human_violation, car_violation, traffic_amount;
   logic       frame_valid, frame_err;
   logic [7:0] frame_cnt, err_cnt;

   uart_frame_parser #(.TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
      .red_left_time(red_left_time), .green_left_time(green_left_time),
      .traffic_light(traffic_light), .human_violation(human_violation),
      .car_violation(car_violation), .traffic_amount(traffic_amount),
      .frame_valid(frame_valid), .frame_err(frame_err),
      .frame_cnt(frame_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic road_frame_t dut_fields();
      road_frame_t r;
      r.x_min = x_min; r.x_max = x_max; r.y_min = y_min; r.y_max = y_max;
      r.red_left_time = red_left_time; r.green_left_time = green_left_time;
      r.traffic_light = traffic_light; r.human_violation = human_violation;
      r.car_violation = car_violation; r.traffic_amount = traffic_amount;
      return r;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      bit          good;
      int          cyc;
      road_frame_t f;
      int          fc;
      int          ec;
   } exp_t;

   exp_t        sb[$];
   int          mbuf[$];
   int          m_idle = 0;
   road_frame_t m_f = '0;
   int          m_fc = 0;
   int          m_ec = 0;

   function automatic bit fmt_pass(int p, int b);
      if (p == 1 || p == 2) return b < 32;
      if (p == 3 || p == 5 || p == 7 || p == 9) return b < 4;
      if (p == 11) return (b % 16) == 0;
      return 1'b1;
   endfunction

   task automatic push_ev(bit good, int c);
      exp_t e;
      e.good = good; e.cyc = c; e.f = m_f; e.fc = m_fc; e.ec = m_ec;
      sb.push_back(e);
   endtask

   task automatic model_err(int c);
      m_ec = (m_ec < 255) ? m_ec + 1 : 255;
      push_ev(1'b0, c);
      mbuf.delete();
   endtask

   task automatic model_step(bit v, int d, int c);
      if (mbuf.size() == 0) begin
         if (v && d == 'hAB) begin mbuf.push_back(d); m_idle = 0; end
      end else if (v) begin
         m_idle = 0;
         if (!fmt_pass(mbuf.size(), d)) begin
            model_err(c);
            if (d == 'hAB) mbuf.push_back(d);
         end else begin
            mbuf.push_back(d);
            if (mbuf.size() == 12) begin
               m_f.red_left_time   = 5'(mbuf[1] % 32);
               m_f.green_left_time = 5'(mbuf[2] % 32);
               m_f.x_min = 10'((mbuf[3] % 4) * 256 + mbuf[4]);
               m_f.x_max = 10'((mbuf[5] % 4) * 256 + mbuf[6]);
               m_f.y_min = 10'((mbuf[7] % 4) * 256 + mbuf[8]);
               m_f.y_max = 10'((mbuf[9] % 4) * 256 + mbuf[10]);
               m_f.traffic_light   = 1'((mbuf[11] / 128) % 2);
               m_f.human_violation = 1'((mbuf[11] / 64) % 2);
               m_f.car_violation   = 1'((mbuf[11] / 32) % 2);
               m_f.traffic_amount  = 1'((mbuf[11] / 16) % 2);
               m_fc = (m_fc + 1) % 256;
               push_ev(1'b1, c);
               mbuf.delete();
            end
         end
      end else begin
         m_idle++;
         if (m_idle == TMO) model_err(c);
      end
   endtask

   // ---------------- monitor ----------------
   // Pulses appear on the cycle after the sampling edge; checked on negedge.
   always @(negedge clk) begin
      exp_t e;
      if (frame_valid || frame_err) begin
         if (sb.size() == 0) begin
            chk("unexpected_pulse", 64'(frame_valid | frame_err), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
            chk("pulse_kind", {62'd0, frame_valid, frame_err}, {62'd0, e.good, ~e.good});
            chk("fields", 64'(dut_fields()), 64'(e.f));
            chk("frame_cnt", 64'(frame_cnt), 64'(e.fc));
            chk("err_cnt", 64'(err_cnt), 64'(e.ec));
         end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         chk(e.good ? "missing_valid" : "missing_err", 64'(frame_valid | frame_err), 64'd1);
      end
   end

   // ---------------- driver ----------------
   task automatic cycle(bit v, logic [7:0] d);
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      model_step(v, int'(d), cyc + 1);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
   endtask

   logic [7:0] good_f [12] = '{8'hAB, 8'h09, 8'h13, 8'h01, 8'h2C, 8'h02,
                               8'h58, 8'h00, 8'h64, 8'h01, 8'h90, 8'hB0};
   logic [7:0] red5_f [12] = '{8'hAB, 8'h05, 8'h13, 8'h01, 8'h2C, 8'h02,
                               8'h58, 8'h00, 8'h64, 8'h01, 8'h90, 8'h00};

   task automatic send_good(int from);
      for (int i = from; i < 12; i++) cycle(1'b1, good_f[i]);
   endtask

   task automatic send_rand_frame(bit corrupt, bit gaps);
      logic [7:0] b [12];
      int pos;
      b[0] = 8'hAB;
      b[1] = 8'($urandom_range(0, 31));
      b[2] = 8'($urandom_range(0, 31));
      for (int i = 3; i <= 9; i += 2) begin
         b[i]   = 8'($urandom_range(0, 3));
         b[i+1] = 8'($urandom_range(0, 255));
      end
      b[11] = 8'($urandom_range(0, 15) * 16);
      if (corrupt) begin
         case ($urandom_range(0, 6))
            0: pos = 1; 1: pos = 2; 2: pos = 3; 3: pos = 5;
            4: pos = 7; 5: pos = 9; default: pos = 11;
         endcase
         if (pos == 11) b[pos] = b[pos] | 8'(1 << $urandom_range(0, 3));
         else           b[pos] = b[pos] | 8'h80;
      end
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, b[i]);
         if (gaps && i < 11) begin
            case ($urandom_range(0, 19))
               0:       idle(TMO - 1);
               1:       idle(TMO);
               2, 3, 4: idle($urandom_range(1, 3));
               default: ;
            endcase
         end
      end
   endtask

   task automatic model_reset();
      mbuf.delete();
      m_idle = 0; m_f = '0; m_fc = 0; m_ec = 0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
      #1;
      chk("rst_fields", 64'(dut_fields()), 64'd0);
      chk("rst_pulses", {62'd0, frame_valid, frame_err}, 64'd0);
      chk("rst_cnts", {48'd0, frame_cnt, err_cnt}, 64'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle(2);

      // Format error on a hi byte; outputs must stay at reset values.
      cycle(1'b1, 8'hAB); cycle(1'b1, 8'h09); cycle(1'b1, 8'h13); cycle(1'b1, 8'hFC);
      idle(3);
      chk("err_keeps_xmin", 64'(x_min), 64'd0);
      chk("err_cnt_1", 64'(err_cnt), 64'd1);
      for (int i = 0; i < 12; i++) cycle(1'b1, red5_f[i]);
      idle(2);
      chk("red_5", 64'(red_left_time), 64'd5);

      // Plain good frame, then leading garbage before another one.
      send_good(0);
      idle(2);
      chk("x_min_300", 64'(x_min), 64'd300);
      chk("x_max_600", 64'(x_max), 64'd600);
      chk("y_min_100", 64'(y_min), 64'd100);
      chk("y_max_400", 64'(y_max), 64'd400);
      chk("red_9", 64'(red_left_time), 64'd9);
      chk("green_19", 64'(green_left_time), 64'd19);
      chk("flags_1011", {60'd0, traffic_light, human_violation, car_violation, traffic_amount}, 64'hB);
      cycle(1'b1, 8'h00); cycle(1'b1, 8'hFF); cycle(1'b1, 8'h12);
      send_good(0);

      // Resync: second header arrives in the green slot.
      cycle(1'b1, 8'hAB); cycle(1'b1, 8'h09);
      send_good(0);
      idle(1);

      // Timeout exactly at the limit, then a byte just in time.
      cycle(1'b1, 8'hAB); cycle(1'b1, 8'h09);
      idle(TMO);
      idle(2);
      cycle(1'b1, 8'hAB); cycle(1'b1, 8'h09);
      idle(TMO - 1);
      send_good(2);
      idle(2);

      // Three frames back to back with zero gap.
      repeat (3) send_good(0);
      idle(2);

      // Error counter saturation.
      repeat (260) begin cycle(1'b1, 8'hAB); cycle(1'b1, 8'hFF); end
      idle(2);
      chk("err_cnt_sat", 64'(err_cnt), 64'd255);

      // Frame counter wrap plus randomized traffic.
      repeat (260) send_rand_frame(1'b0, 1'b0);
      repeat (250) begin
         if ($urandom_range(0, 3) == 0) cycle(1'b1, 8'($urandom_range(0, 255)));
         send_rand_frame($urandom_range(0, 3) == 0, 1'b1);
      end
      idle(TMO + 2);

      // Asynchronous reset in the middle of a frame.
      cycle(1'b1, 8'hAB); cycle(1'b1, 8'h01); cycle(1'b1, 8'h02);
      @(negedge clk);
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      model_reset();
      chk("midrst_fields", 64'(dut_fields()), 64'd0);
      chk("midrst_cnts", {48'd0, frame_cnt, err_cnt}, 64'd0);
      chk("midrst_pulses", {62'd0, frame_valid, frame_err}, 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      idle(TMO + 5);
      send_good(0);
      idle(3);
      chk("post_rst_frame_cnt", 64'(frame_cnt), 64'd1);
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
